audio_mixer: RTL and testbench

- Clocked source mixer between the audio producers and the audio output filter/resampler.
- Producers: SuperSprite PSG (16-bit), Mockingboard L/R (10-bit), Apple speaker (1-bit).
- Per-source gain, speaker DC-decay, signed summation and saturation, producing offset-binary 16-bit L/R words for the output stage.
- Also provides a stretched clip indicator for the LEDs and a small register-write port for gains and mute.

---
 rtl/audio_mixer.sv | 182 ++++++++++++++++++
 tb/tb_audio_mixer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer.sv
// Four-stage audio source mixer: PSG, Mockingboard L/R and speaker are converted to signed,
// scaled by per-source gain, summed and saturated into offset-binary 16-bit L/R words.
module audio_mixer #(
  parameter int SPK_AMP     = 8192,
  parameter int IDLE_CYCLES = 2_700_000,
  parameter int DECAY_DIV   = 64,
  parameter int CLIP_HOLD   = 2_700_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ssp_audio_i,
  input  logic [9:0]  mb_audio_l_i,
  input  logic [9:0]  mb_audio_r_i,
  input  logic        speaker_i,
  input  logic        cfg_wr_i,
  input  logic [1:0]  cfg_addr_i,
  input  logic [7:0]  cfg_data_i,
  output logic [15:0] audio_l_o,
  output logic [15:0] audio_r_o,
  output logic        clip_o
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int CW = $clog2(CLIP_HOLD + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
  localparam logic [DW-1:0] DIV_LAST = DW'(DECAY_DIV - 1);
  localparam logic [CW-1:0] CLIP_MAX = CW'(CLIP_HOLD);
  localparam logic signed [15:0] SPK_POS = 16'(SPK_AMP);
  localparam logic signed [15:0] SPK_NEG = 16'(-SPK_AMP);

  function automatic logic signed [15:0] mb_conv(input logic [9:0] v);
    logic [9:0] c;
    c = v ^ 10'h200;
    return {c[9], c, 5'b00000};
  endfunction

  function automatic logic signed [17:0] apply_gain(input logic signed [15:0] s,
                                                    input logic [3:0] g);
    logic signed [20:0] p;
    p = 21'(s) * $signed({17'd0, g});
    return p[20:3];
  endfunction

  // Bit 16 flags a clamp; bits 15:0 are the offset-binary result.
  function automatic logic [16:0] saturate(input logic signed [19:0] v);
    if (v > 20'sd32767)       return {1'b1, 16'hFFFF};
    else if (v < -20'sd32768) return {1'b1, 16'h0000};
    else                      return {1'b0, v[15:0] ^ 16'h8000};
  endfunction

  // ---------------- configuration registers ----------------
  logic [3:0] ssp_gain, mb_gain, spk_gain;
  logic       mute;
  logic       clip_clr;
  logic       unused_cfg;

  assign clip_clr   = cfg_wr_i && (cfg_addr_i == 2'd3) && cfg_data_i[1];
  assign unused_cfg = ^cfg_data_i[7:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssp_gain <= 4'd8;
      mb_gain  <= 4'd8;
      spk_gain <= 4'd8;
      mute     <= 1'b0;
    end else if (cfg_wr_i) begin
      case (cfg_addr_i)
        2'd0:    ssp_gain <= cfg_data_i[3:0];
        2'd1:    mb_gain  <= cfg_data_i[3:0];
        2'd2:    spk_gain <= cfg_data_i[3:0];
        default: mute     <= cfg_data_i[0];
      endcase
    end
  end

  // ---------------- stage 1: convert to signed ----------------
  logic signed [15:0] ssp_s1, mbl_s1, mbr_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssp_s1 <= '0;
      mbl_s1 <= '0;
      mbr_s1 <= '0;
    end else begin
      ssp_s1 <= $signed(ssp_audio_i ^ 16'h8000);
      mbl_s1 <= mb_conv(mb_audio_l_i);
      mbr_s1 <= mb_conv(mb_audio_r_i);
    end
  end

  // ---------------- speaker level with idle decay ----------------
  logic               spk_q;
  logic               spk_edge;
  logic signed [15:0] spk_lvl;
  logic [IW-1:0]      idle_cnt;
  logic [DW-1:0]      div_cnt;

  assign spk_edge = speaker_i != spk_q;

  // An edge always restarts at full amplitude, even on a decay-step clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_q    <= 1'b0;
      spk_lvl  <= '0;
      idle_cnt <= '0;
      div_cnt  <= '0;
    end else begin
      spk_q <= speaker_i;
      if (spk_edge) begin
        spk_lvl  <= speaker_i ? SPK_POS : SPK_NEG;
        idle_cnt <= '0;
        div_cnt  <= '0;
      end else if (idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + IW'(1);
      end else if (div_cnt != DIV_LAST) begin
        div_cnt <= div_cnt + DW'(1);
      end else begin
        div_cnt <= '0;
        if (spk_lvl > 16'sd0)      spk_lvl <= spk_lvl - 16'sd1;
        else if (spk_lvl < 16'sd0) spk_lvl <= spk_lvl + 16'sd1;
      end
    end
  end

  // ---------------- stage 2: gain ----------------
  logic signed [17:0] ssp_g, mbl_g, mbr_g, spk_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssp_g <= '0;
      mbl_g <= '0;
      mbr_g <= '0;
      spk_g <= '0;
    end else begin
      ssp_g <= apply_gain(ssp_s1, ssp_gain);
      mbl_g <= apply_gain(mbl_s1, mb_gain);
      mbr_g <= apply_gain(mbr_s1, mb_gain);
      spk_g <= apply_gain(spk_lvl, spk_gain);
    end
  end

  // ---------------- stage 3: sum ----------------
  logic signed [19:0] sum_l, sum_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_l <= '0;
      sum_r <= '0;
    end else begin
      sum_l <= 20'(ssp_g) + 20'(mbl_g) + 20'(spk_g);
      sum_r <= 20'(ssp_g) + 20'(mbr_g) + 20'(spk_g);
    end
  end

  // ---------------- stage 4: saturate, mute, clip ----------------
  logic [16:0]   sat_l, sat_r;
  logic [CW-1:0] clip_cnt;

  always_comb begin
    sat_l = saturate(sum_l);
    sat_r = saturate(sum_r);
  end

  // Clip detection looks at the clamp itself, so it still fires while muted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_l_o <= 16'h8000;
      audio_r_o <= 16'h8000;
      clip_cnt  <= '0;
    end else begin
      audio_l_o <= mute ? 16'h8000 : sat_l[15:0];
      audio_r_o <= mute ? 16'h8000 : sat_r[15:0];
      if (clip_clr)                 clip_cnt <= '0;
      else if (sat_l[16] | sat_r[16]) clip_cnt <= CLIP_MAX;
      else if (clip_cnt != '0)      clip_cnt <= clip_cnt - CW'(1);
    end
  end

  assign clip_o = clip_cnt != '0;

endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer: directed literal checks plus randomized traffic compared every
// cycle against an arithmetic model of the mixer's input-to-output rules.
module tb_audio_mixer;

  localparam int SPK_AMP     = 8192;
  localparam int IDLE_CYCLES = 100;
  localparam int DECAY_DIV   = 2;
  localparam int CLIP_HOLD   = 20;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ssp_audio_i;
  logic [9:0]  mb_audio_l_i, mb_audio_r_i;
  logic        speaker_i;
  logic        cfg_wr_i;
  logic [1:0]  cfg_addr_i;
  logic [7:0]  cfg_data_i;
  logic [15:0] audio_l_o, audio_r_o;
  logic        clip_o;

  always #5 clk = ~clk;

  audio_mixer #(
    .SPK_AMP(SPK_AMP), .IDLE_CYCLES(IDLE_CYCLES),
    .DECAY_DIV(DECAY_DIV), .CLIP_HOLD(CLIP_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ssp_audio_i(ssp_audio_i), .mb_audio_l_i(mb_audio_l_i), .mb_audio_r_i(mb_audio_r_i),
    .speaker_i(speaker_i), .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i),
    .cfg_data_i(cfg_data_i), .audio_l_o(audio_l_o), .audio_r_o(audio_r_o), .clip_o(clip_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          g_ssp, g_mb, g_spk;
  bit          m_mute;
  bit          sp_prev;
  int          sp_sign, sp_since;
  int          s1_ssp, s1_mbl, s1_mbr, s1_spk;
  int          d1_l, d1_r, d2_l, d2_r;
  int          clip_left;
  int          cl, cr;
  bit          sat;
  logic [15:0] ol, orr;
  logic [32:0] exp_q[$];
  logic [32:0] exp_w;

  function automatic int spk_level(input int sign, input int since);
    int mag;
    mag = SPK_AMP;
    if (since > IDLE_CYCLES) mag = SPK_AMP - (since - IDLE_CYCLES) / DECAY_DIV;
    if (mag < 0) mag = 0;
    return sign * mag;
  endfunction

  function automatic int gained(input int x, input int g);
    return (x * g) >>> 3;
  endfunction

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Output after a clock = sum of inputs sampled three clocks earlier, gained with the gains
  // in force two clocks earlier, muted by the mute in force just before the clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_ssp = 8; g_mb = 8; g_spk = 8; m_mute = 0;
      sp_prev = 0; sp_sign = 0; sp_since = 0;
      s1_ssp = 0; s1_mbl = 0; s1_mbr = 0; s1_spk = 0;
      d1_l = 0; d1_r = 0; d2_l = 0; d2_r = 0;
      clip_left = 0;
      exp_q.delete();
    end else begin
      cl  = clamp(d2_l);
      cr  = clamp(d2_r);
      sat = (cl != d2_l) || (cr != d2_r);
      ol  = m_mute ? 16'h8000 : (16'(cl) ^ 16'h8000);
      orr = m_mute ? 16'h8000 : (16'(cr) ^ 16'h8000);
      if (cfg_wr_i && cfg_addr_i == 2'd3 && cfg_data_i[1]) clip_left = 0;
      else if (sat)                                        clip_left = CLIP_HOLD;
      else if (clip_left > 0)                              clip_left--;
      exp_q.push_back({clip_left != 0, ol, orr});
      d2_l = d1_l;
      d2_r = d1_r;
      d1_l = gained(s1_ssp, g_ssp) + gained(s1_mbl, g_mb) + gained(s1_spk, g_spk);
      d1_r = gained(s1_ssp, g_ssp) + gained(s1_mbr, g_mb) + gained(s1_spk, g_spk);
      if (speaker_i != sp_prev) begin
        sp_sign  = speaker_i ? 1 : -1;
        sp_since = 0;
      end else if (sp_since < 1_000_000) begin
        sp_since++;
      end
      sp_prev = speaker_i;
      s1_ssp = int'(ssp_audio_i) - 32768;
      s1_mbl = (int'(mb_audio_l_i) - 512) * 32;
      s1_mbr = (int'(mb_audio_r_i) - 512) * 32;
      s1_spk = spk_level(sp_sign, sp_since);
      if (cfg_wr_i) begin
        case (cfg_addr_i)
          2'd0: g_ssp = int'(cfg_data_i[3:0]);
          2'd1: g_mb  = int'(cfg_data_i[3:0]);
          2'd2: g_spk = int'(cfg_data_i[3:0]);
          default: m_mute = cfg_data_i[0];
        endcase
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      check("model_l", audio_l_o, exp_w[31:16]);
      check("model_r", audio_r_o, exp_w[15:0]);
      check("model_clip", {15'd0, clip_o}, {15'd0, exp_w[32]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_wr_i   = 1'b1;
    cfg_addr_i = a;
    cfg_data_i = d;
    @(negedge clk);
    cfg_wr_i   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      ssp_audio_i  = 16'($urandom);
      mb_audio_l_i = 10'($urandom_range(0, 1023));
      mb_audio_r_i = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) speaker_i = ~speaker_i;
      cfg_wr_i   = ($urandom_range(0, 7) == 0);
      cfg_addr_i = 2'($urandom_range(0, 3));
      if (cfg_addr_i == 2'd3)
        cfg_data_i = {6'd0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
      else
        cfg_data_i = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    cfg_wr_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ssp_audio_i = 16'h8000; mb_audio_l_i = 10'd512; mb_audio_r_i = 10'd512;
    speaker_i = 1'b0; cfg_wr_i = 1'b0; cfg_addr_i = 2'd0; cfg_data_i = 8'd0;
    step(3);
    check("rst_l", audio_l_o, 16'h8000);
    check("rst_r", audio_r_o, 16'h8000);
    check("rst_clip", {15'd0, clip_o}, 16'd0);
    #2 rst_n = 1'b1;
    step(8);
    check("idle_l", audio_l_o, 16'h8000);
    check("idle_r", audio_r_o, 16'h8000);

    // latency
    ssp_audio_i = 16'hA000;
    step(3);
    check("lat3_l", audio_l_o, 16'h8000);
    step(1);
    check("lat4_l", audio_l_o, 16'hA000);
    check("lat4_r", audio_r_o, 16'hA000);

    // Mockingboard gain
    ssp_audio_i = 16'h8000;
    wr(2'd1, 8'd4);
    mb_audio_l_i = 10'd1023;
    mb_audio_r_i = 10'd0;
    step(5);
    check("gain_l", audio_l_o, 16'h9FF0);
    check("gain_r", audio_r_o, 16'h6000);

    // mute and unmute
    wr(2'd3, 8'h01);
    step(1);
    check("mute_l", audio_l_o, 16'h8000);
    check("mute_r", audio_r_o, 16'h8000);
    wr(2'd3, 8'h00);
    check("unmute_still_l", audio_l_o, 16'h8000);
    step(1);
    check("unmute_l", audio_l_o, 16'h9FF0);

    // saturation and clip clear
    wr(2'd0, 8'd15); wr(2'd1, 8'd15); wr(2'd2, 8'd15);
    ssp_audio_i = 16'hFFFF; mb_audio_l_i = 10'd1023; mb_audio_r_i = 10'd512;
    step(5);
    check("sat_l", audio_l_o, 16'hFFFF);
    check("sat_clip", {15'd0, clip_o}, 16'd1);
    wr(2'd3, 8'h02);
    check("clr_clip", {15'd0, clip_o}, 16'd0);
    step(1);
    check("retrig_clip", {15'd0, clip_o}, 16'd1);
    ssp_audio_i = 16'h8000; mb_audio_l_i = 10'd512;
    wr(2'd0, 8'd8); wr(2'd1, 8'd8); wr(2'd2, 8'd8);
    step(CLIP_HOLD + 10);
    check("clip_drop", {15'd0, clip_o}, 16'd0);

    // speaker decay
    speaker_i = 1'b1;
    step(4);
    check("spk_pos_l", audio_l_o, 16'hA000);
    step(300);
    speaker_i = 1'b0;
    step(4);
    check("spk_neg_l", audio_l_o, 16'h6000);
    check("spk_neg_r", audio_r_o, 16'h6000);
    step(300);
    check("spk_decay100_l", audio_l_o, 16'h6064);
    step(IDLE_CYCLES + 2 * SPK_AMP - 1 - 300);
    check("spk_last_l", audio_l_o, 16'h7FFF);
    step(1);
    check("spk_zero_l", audio_l_o, 16'h8000);

    // randomized traffic with a mid-stream reset
    rand_traffic(1500);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_l", audio_l_o, 16'h8000);
    check("mrst_r", audio_r_o, 16'h8000);
    check("mrst_clip", {15'd0, clip_o}, 16'd0);
    speaker_i = 1'b0;
    step(2);
    #2 rst_n = 1'b1;
    step(1);
    rand_traffic(1500);
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
